// File: rtl/sdf_butterfly_stage.sv
// Radix-2 single-delay-feedback butterfly stage: the first half-block fills the delay line,
// the second half emits halved sums and feeds halved differences back for the next block.
module sdf_butterfly_stage #(
  parameter int unsigned INTEGER_SIZE = 8,
  parameter int unsigned FRACT_SIZE   = 8,
  parameter int unsigned DELAY        = 32,
  localparam int unsigned DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE,
  localparam int unsigned CW          = $clog2(DELAY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic                  tw_en,
  output logic [CW-1:0]         tw_index
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned CNTW = CW + 1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            primed_q, primed_d;
  logic [DW-1:0]   dl_r_q [DELAY];
  logic [DW-1:0]   dl_i_q [DELAY];
  logic [DW-1:0]   dl_r_d [DELAY];
  logic [DW-1:0]   dl_i_d [DELAY];
  logic [DW-1:0]   out_r_q, out_r_d;
  logic [DW-1:0]   out_i_q, out_i_d;
  logic            valid_q, valid_d;
  logic            tw_en_q, tw_en_d;
  logic [CW-1:0]   tw_index_q, tw_index_d;

  logic [DW-1:0]   fb_r, fb_i;
  logic [DW:0]     sum_r, sum_i, dif_r, dif_i;

  // Butterfly arithmetic one bit wider so the halved result can never overflow.
  always_comb begin
    fb_r  = dl_r_q[DELAY-1];
    fb_i  = dl_i_q[DELAY-1];
    sum_r = {fb_r[DW-1], fb_r} + {in_r[DW-1], in_r};
    sum_i = {fb_i[DW-1], fb_i} + {in_i[DW-1], in_i};
    dif_r = {fb_r[DW-1], fb_r} - {in_r[DW-1], in_r};
    dif_i = {fb_i[DW-1], fb_i} - {in_i[DW-1], in_i};
  end

  always_comb begin
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    dl_r_d     = dl_r_q;
    dl_i_d     = dl_i_q;
    out_r_d    = out_r_q;
    out_i_d    = out_i_q;
    valid_d    = 1'b0;
    tw_en_d    = 1'b0;
    tw_index_d = tw_index_q;
    if (valid_in) begin
      cnt_d = cnt_q + CNTW'(1);
      for (int i = 1; i < int'(DELAY); i++) begin
        dl_r_d[i] = dl_r_q[i-1];
        dl_i_d[i] = dl_i_q[i-1];
      end
      if (!cnt_q[CW]) begin
        // Fill: emit the previous block's difference term, store the new sample.
        dl_r_d[0]  = in_r;
        dl_i_d[0]  = in_i;
        out_r_d    = fb_r;
        out_i_d    = fb_i;
        tw_en_d    = 1'b1;
        tw_index_d = cnt_q[CW-1:0];
        valid_d    = primed_q;
      end else begin
        dl_r_d[0]  = dif_r[DW:1];
        dl_i_d[0]  = dif_i[DW:1];
        out_r_d    = sum_r[DW:1];
        out_i_d    = sum_i[DW:1];
        tw_en_d    = 1'b0;
        tw_index_d = '0;
        primed_d   = 1'b1;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      out_r_q    <= '0;
      out_i_q    <= '0;
      valid_q    <= 1'b0;
      tw_en_q    <= 1'b0;
      tw_index_q <= '0;
      for (int i = 0; i < int'(DELAY); i++) begin
        dl_r_q[i] <= '0;
        dl_i_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      out_r_q    <= out_r_d;
      out_i_q    <= out_i_d;
      valid_q    <= valid_d;
      tw_en_q    <= tw_en_d;
      tw_index_q <= tw_index_d;
      for (int i = 0; i < int'(DELAY); i++) begin
        dl_r_q[i] <= dl_r_d[i];
        dl_i_q[i] <= dl_i_d[i];
      end
    end
  end

  assign valid_out = valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign tw_en     = tw_en_q;
  assign tw_index  = tw_index_q;

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Bench for sdf_butterfly_stage (DELAY=2, Q8.8): directed scenarios plus random traffic,
// checked against a queue-based behavioural model of the stage.
module tb_sdf_butterfly_stage;

  localparam int unsigned D  = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [W-1:0]  in_r = '0;
  logic [W-1:0]  in_i = '0;
  logic          valid_out;
  logic [W-1:0]  out_r, out_i;
  logic          tw_en;
  logic [CW-1:0] tw_index;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a FIFO of the D most recently stored complex values.
  int   q_r[$];
  int   q_i[$];
  int   mcnt;
  bit   mprimed;
  logic         e_v, e_twen;
  logic [W-1:0] e_r, e_i;
  logic [CW-1:0] e_idx;

  sdf_butterfly_stage #(.INTEGER_SIZE(8), .FRACT_SIZE(8), .DELAY(D)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in_r(in_r), .in_i(in_i),
    .valid_out(valid_out), .out_r(out_r), .out_i(out_i),
    .tw_en(tw_en), .tw_index(tw_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_r.delete();
    q_i.delete();
    for (int k = 0; k < int'(D); k++) begin
      q_r.push_back(0);
      q_i.push_back(0);
    end
    mcnt    = 0;
    mprimed = 0;
    e_v = 0; e_twen = 0; e_r = '0; e_i = '0; e_idx = '0;
  endtask

  task automatic model_sample(input logic [W-1:0] r, input logic [W-1:0] i);
    int fr, fi, xr, xi;
    fr = q_r.pop_front();
    fi = q_i.pop_front();
    xr = int'($signed(r));
    xi = int'($signed(i));
    if (mcnt < int'(D)) begin
      q_r.push_back(xr);
      q_i.push_back(xi);
      e_r = W'(fr); e_i = W'(fi);
      e_twen = 1; e_idx = CW'(mcnt % int'(D));
      e_v = mprimed;
    end else begin
      q_r.push_back((fr - xr) >>> 1);
      q_i.push_back((fi - xi) >>> 1);
      e_r = W'((fr + xr) >>> 1);
      e_i = W'((fi + xi) >>> 1);
      e_twen = 0; e_idx = '0;
      mprimed = 1;
      e_v = 1;
    end
    mcnt = (mcnt + 1) % int'(2 * D);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(e_v));
    chk({tag, ".out_r"},     32'(out_r),     32'(e_r));
    chk({tag, ".out_i"},     32'(out_i),     32'(e_i));
    chk({tag, ".tw_en"},     32'(tw_en),     32'(e_twen));
    chk({tag, ".tw_index"},  32'(tw_index),  32'(e_idx));
  endtask

  task automatic step(input string tag, input bit v, input logic [W-1:0] r, input logic [W-1:0] i);
    @(negedge clk);
    valid_in = v; in_r = r; in_i = i;
    @(posedge clk);
    #1;
    if (v) model_sample(r, i);
    else begin
      e_v = 0; e_twen = 0;
    end
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'd0);
    chk({tag, ".out_r"},     32'(out_r),     32'd0);
    chk({tag, ".out_i"},     32'(out_i),     32'd0);
    chk({tag, ".tw_en"},     32'(tw_en),     32'd0);
    chk({tag, ".tw_index"},  32'(tw_index),  32'd0);
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must clear immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1 check_zero({tag, ".async"});
    @(posedge clk);
    #1 check_zero({tag, ".held"});
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic replay_basic(input string tag);
    step({tag, ".s0"}, 1, 16'h0100, 16'h0000);
    chk({tag, ".s0_vout"}, 32'(valid_out), 32'd0);
    step({tag, ".s1"}, 1, 16'h0200, 16'h0000);
    chk({tag, ".s1_vout"}, 32'(valid_out), 32'd0);
    step({tag, ".s2"}, 1, 16'h0300, 16'h0000);
    chk({tag, ".s2_out"}, 32'({valid_out, tw_en, out_r}), 32'({1'b1, 1'b0, 16'h0200}));
    step({tag, ".s3"}, 1, 16'h0400, 16'h0000);
    chk({tag, ".s3_out"}, 32'({valid_out, tw_en, out_r}), 32'({1'b1, 1'b0, 16'h0300}));
    step({tag, ".s4"}, 1, 16'h0000, 16'h0000);
    chk({tag, ".s4_out"}, 32'({valid_out, tw_en, tw_index, out_r}), 32'({1'b1, 1'b1, 1'b0, 16'hFF00}));
    step({tag, ".s5"}, 1, 16'h0000, 16'h0000);
    chk({tag, ".s5_out"}, 32'({valid_out, tw_en, tw_index, out_r}), 32'({1'b1, 1'b1, 1'b1, 16'hFF00}));
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1 check_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // Unprimed fill, first sums, then the previous block's differences.
    replay_basic("basic");

    // Same block with three idle cycles between samples.
    do_reset("rst_gap");
    begin
      logic [W-1:0] gap_vals [4];
      gap_vals[0] = 16'h0100; gap_vals[1] = 16'h0200;
      gap_vals[2] = 16'h0300; gap_vals[3] = 16'h0400;
      for (int k = 0; k < 4; k++) begin
        step("gap.smp", 1, gap_vals[k], 16'h0000);
        for (int g = 0; g < 3; g++)
          step("gap.idle", 0, W'($urandom), W'($urandom));
      end
      chk("gap.held_out_r", 32'(out_r), 32'h0300);
    end

    // Saturation corners: full-scale sums must not wrap, -1/2 floors to -1.
    do_reset("rst_sat");
    for (int k = 0; k < 4; k++) begin
      step("sat.smp", 1, 16'h7FFF, 16'h8000);
      if (k >= 2) begin
        chk("sat.sum_r", 32'(out_r), 32'h7FFF);
        chk("sat.sum_i", 32'(out_i), 32'h8000);
      end
    end
    step("sat.fill0", 1, 16'hFFFF, 16'h0000);
    step("sat.fill1", 1, 16'h0000, 16'h0000);
    step("sat.bfly0", 1, 16'h0000, 16'h0000);
    chk("sat.neg_half", 32'(out_r), 32'hFFFF);
    step("sat.bfly1", 1, 16'h0000, 16'h0000);

    // Reset mid-block discards partial data; replay must match the clean run.
    do_reset("rst_pre");
    step("mid.s0", 1, 16'h1234, 16'h0101);
    step("mid.s1", 1, 16'h2345, 16'h0202);
    step("mid.s2", 1, 16'h3456, 16'h0303);
    do_reset("rst_mid");
    replay_basic("replay");

    // Random traffic with random gaps and complex data.
    do_reset("rst_rand");
    for (int k = 0; k < 400; k++)
      step("rand", ($urandom_range(0, 9) < 7), W'($urandom), W'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
